// File: rtl/drawbridge_ctrl_mlane.sv
// Multi-lane drawbridge controller: saturating occupancy counter plus the
// alert/clear/raise/open/lower sequencer driving the barrier, lights and motor.
module drawbridge_ctrl_mlane #(
   parameter int N_LANES   = 2,
   parameter int CNT_W     = 4,
   parameter int ALERT_CYC = 4,
   parameter int RAISE_CYC = 8,
   parameter int LOWER_CYC = 8,
   parameter int OPEN_MIN  = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [N_LANES-1:0] i_carIn,
   input  logic [N_LANES-1:0] i_carOut,
   input  logic               i_boatClose,
   input  logic               i_boatHere,
   output logic               o_carBarrier,
   output logic               o_alert,
   output logic [2:0]         o_bridge_s,
   output logic [CNT_W-1:0]   o_carCount,
   output logic               has_car_c,
   output logic               o_error
);

   typedef enum logic [2:0] {
      DOWN     = 3'd0,
      ALERT    = 3'd1,
      CLEARING = 3'd2,
      RAISING  = 3'd3,
      UP       = 3'd4,
      LOWERING = 3'd5
   } state_t;

   localparam int SW   = CNT_W + 4;
   localparam int TMAX_A = (ALERT_CYC > RAISE_CYC) ? ALERT_CYC : RAISE_CYC;
   localparam int TMAX_B = (LOWER_CYC > OPEN_MIN) ? LOWER_CYC : OPEN_MIN;
   localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
   localparam int TW     = $clog2(TMAX + 1);

   localparam logic [TW-1:0] ALERT_T = TW'(ALERT_CYC);
   localparam logic [TW-1:0] RAISE_T = TW'(RAISE_CYC);
   localparam logic [TW-1:0] LOWER_T = TW'(LOWER_CYC);
   localparam logic [TW-1:0] OPEN_T  = TW'(OPEN_MIN);
   localparam logic [TW-1:0] T_ONE   = TW'(1);
   localparam logic signed [SW-1:0] MAX_S = SW'((1 << CNT_W) - 1);

   state_t             state_reg;
   logic [TW-1:0]      timer_reg;
   logic [CNT_W-1:0]   count_reg;
   logic               has_car_reg;
   logic               barrier_reg;
   logic               alert_reg;
   logic               error_reg;

   logic signed [SW-1:0] sum_next;
   logic [CNT_W-1:0]     count_next;
   logic                 clamp_next;
   logic                 boat;

   assign boat = i_boatClose | i_boatHere;

   // Net lane activity is summed wide and signed so both clamps are visible.
   always_comb begin
      sum_next = $signed({4'b0000, count_reg});
      for (int i = 0; i < N_LANES; i++) begin
         sum_next = sum_next + $signed({{(SW-1){1'b0}}, i_carIn[i]})
                             - $signed({{(SW-1){1'b0}}, i_carOut[i]});
      end
      clamp_next = 1'b0;
      count_next = sum_next[CNT_W-1:0];
      if (sum_next < 0) begin
         count_next = '0;
         clamp_next = 1'b1;
      end else if (sum_next > MAX_S) begin
         count_next = MAX_S[CNT_W-1:0];
         clamp_next = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg   <= DOWN;
         timer_reg   <= '0;
         count_reg   <= '0;
         has_car_reg <= 1'b0;
         barrier_reg <= 1'b0;
         alert_reg   <= 1'b0;
         error_reg   <= 1'b0;
      end else begin
         count_reg   <= count_next;
         has_car_reg <= (count_next != '0);
         if (clamp_next || ((|i_carIn) && barrier_reg))
            error_reg <= 1'b1;

         case (state_reg)
            DOWN: begin
               if (boat) begin
                  state_reg <= ALERT;
                  timer_reg <= ALERT_T;
                  alert_reg <= 1'b1;
               end
            end
            ALERT: begin
               if (timer_reg == T_ONE) begin
                  state_reg   <= CLEARING;
                  barrier_reg <= 1'b1;
               end else begin
                  timer_reg <= timer_reg - T_ONE;
               end
            end
            // Wait on the post-update count so the last car leaving raises at once.
            CLEARING: begin
               if (count_next == '0) begin
                  state_reg <= RAISING;
                  timer_reg <= RAISE_T;
               end
            end
            RAISING: begin
               if (timer_reg == T_ONE) begin
                  state_reg <= UP;
                  timer_reg <= OPEN_T;
                  alert_reg <= 1'b0;
               end else begin
                  timer_reg <= timer_reg - T_ONE;
               end
            end
            // Timer parks at 1 once the minimum open time has elapsed.
            UP: begin
               if (timer_reg == T_ONE) begin
                  if (!boat) begin
                     state_reg <= LOWERING;
                     timer_reg <= LOWER_T;
                     alert_reg <= 1'b1;
                  end
               end else begin
                  timer_reg <= timer_reg - T_ONE;
               end
            end
            LOWERING: begin
               if (boat) begin
                  state_reg <= RAISING;
                  timer_reg <= RAISE_T;
               end else if (timer_reg == T_ONE) begin
                  state_reg   <= DOWN;
                  timer_reg   <= '0;
                  barrier_reg <= 1'b0;
                  alert_reg   <= 1'b0;
               end else begin
                  timer_reg <= timer_reg - T_ONE;
               end
            end
            default: begin
               state_reg   <= DOWN;
               timer_reg   <= '0;
               barrier_reg <= 1'b0;
               alert_reg   <= 1'b0;
               error_reg   <= 1'b1;
            end
         endcase
      end
   end

   assign o_bridge_s   = state_reg;
   assign o_carBarrier = barrier_reg;
   assign o_alert      = alert_reg;
   assign o_carCount   = count_reg;
   assign has_car_c    = has_car_reg;
   assign o_error      = error_reg;

endmodule

// File: tb/tb_drawbridge_ctrl_mlane.sv
// Bench for drawbridge_ctrl_mlane: directed sequences, literal checkpoints and
// a per-cycle comparison against a phase/age behavioural model.
module tb_drawbridge_ctrl_mlane;

   localparam int N_LANES   = 2;
   localparam int CNT_W     = 4;
   localparam int ALERT_CYC = 4;
   localparam int RAISE_CYC = 8;
   localparam int LOWER_CYC = 8;
   localparam int OPEN_MIN  = 16;
   localparam int CMAX      = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [N_LANES-1:0] car_in = '0;
   logic [N_LANES-1:0] car_out = '0;
   logic               boat_close = 1'b0;
   logic               boat_here = 1'b0;
   logic               barrier;
   logic               alert;
   logic [2:0]         bridge_s;
   logic [CNT_W-1:0]   car_count;
   logic               has_car;
   logic               error;

   int tests = 0;
   int fails = 0;

   drawbridge_ctrl_mlane #(
      .N_LANES(N_LANES), .CNT_W(CNT_W), .ALERT_CYC(ALERT_CYC),
      .RAISE_CYC(RAISE_CYC), .LOWER_CYC(LOWER_CYC), .OPEN_MIN(OPEN_MIN)
   ) dut (
      .i_clk(clk), .i_reset(rst), .i_carIn(car_in), .i_carOut(car_out),
      .i_boatClose(boat_close), .i_boatHere(boat_here),
      .o_carBarrier(barrier), .o_alert(alert), .o_bridge_s(bridge_s),
      .o_carCount(car_count), .has_car_c(has_car), .o_error(error)
   );

   always #5 clk = ~clk;

   // Model: phase number, cycles spent in the phase, occupancy, error flag.
   typedef struct {
      int st;
      int age;
      int cnt;
      bit err;
   } mstate_t;

   mstate_t m;
   bit      started = 1'b0;

   function automatic bit barrier_of(input int st);
      return (st >= 2 && st <= 5);
   endfunction

   function automatic bit alert_of(input int st);
      return (st == 1 || st == 2 || st == 3 || st == 5);
   endfunction

   function automatic mstate_t model_next(input mstate_t c, input logic [N_LANES-1:0] ci,
                                          input logic [N_LANES-1:0] co, input bit bc,
                                          input bit bh, input bit r);
      mstate_t n;
      int raw;
      int ns;
      bit b;
      if (r) begin
         n.st = 0; n.age = 1; n.cnt = 0; n.err = 1'b0;
         return n;
      end
      n = c;
      raw = c.cnt + $countones(ci) - $countones(co);
      if (raw < 0) begin
         n.cnt = 0; n.err = 1'b1;
      end else if (raw > CMAX) begin
         n.cnt = CMAX; n.err = 1'b1;
      end else begin
         n.cnt = raw;
      end
      if (ci != '0 && barrier_of(c.st)) n.err = 1'b1;
      b = bc || bh;
      ns = c.st;
      case (c.st)
         0: if (b) ns = 1;
         1: if (c.age >= ALERT_CYC) ns = 2;
         2: if (n.cnt == 0) ns = 3;
         3: if (c.age >= RAISE_CYC) ns = 4;
         4: if (c.age >= OPEN_MIN && !b) ns = 5;
         5: if (b) ns = 3; else if (c.age >= LOWER_CYC) ns = 0;
         default: ns = 0;
      endcase
      n.age = (ns != c.st) ? 1 : c.age + 1;
      n.st  = ns;
      return n;
   endfunction

   always @(posedge clk) begin
      m <= model_next(m, car_in, car_out, boat_close, boat_here, rst);
      if (rst) started <= 1'b1;
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (started) begin
         chk("model_state",   int'(bridge_s), m.st);
         chk("model_barrier", int'(barrier), int'(barrier_of(m.st)));
         chk("model_alert",   int'(alert), int'(alert_of(m.st)));
         chk("model_count",   int'(car_count), m.cnt);
         chk("model_has_car", int'(has_car), int'(m.cnt != 0));
         chk("model_error",   int'(error), int'(m.err));
      end
   end

   task automatic step(input logic [N_LANES-1:0] ci, input logic [N_LANES-1:0] co,
                       input logic bc, input logic bh);
      car_in = ci; car_out = co; boat_close = bc; boat_here = bh;
      @(negedge clk);
   endtask

   task automatic chk_state(input string name, input int st, input int bar, input int al);
      chk({name, "_state"}, int'(bridge_s), st);
      chk({name, "_barrier"}, int'(barrier), bar);
      chk({name, "_alert"}, int'(alert), al);
   endtask

   initial begin
      rst = 1'b1;
      step(2'b00, 2'b00, 0, 0);
      step(2'b00, 2'b00, 0, 0);
      chk_state("reset", 0, 0, 0);
      chk("reset_count", int'(car_count), 0);
      chk("reset_error", int'(error), 0);
      rst = 1'b0;

      // Two lanes then one lane entering.
      step(2'b11, 2'b00, 0, 0);
      chk("count_after_11", int'(car_count), 2);
      step(2'b01, 2'b00, 0, 0);
      chk("count_after_01", int'(car_count), 3);
      chk("has_car_3", int'(has_car), 1);
      chk("no_error_3", int'(error), 0);
      step(2'b00, 2'b01, 0, 0);
      chk("count_2", int'(car_count), 2);

      // Full opening sequence with two cars to clear.
      step(2'b00, 2'b00, 1, 0);
      chk_state("alert_1", 1, 0, 1);
      for (int k = 2; k <= ALERT_CYC; k++) begin
         step(2'b00, 2'b00, 1, 0);
         chk_state("alert_k", 1, 0, 1);
      end
      step(2'b00, 2'b00, 1, 0);
      chk_state("clearing_1", 2, 1, 1);
      step(2'b00, 2'b00, 1, 0);
      chk_state("clearing_2", 2, 1, 1);
      step(2'b00, 2'b01, 1, 0);
      chk_state("clearing_last", 2, 1, 1);
      chk("clearing_count1", int'(car_count), 1);
      step(2'b00, 2'b10, 1, 0);
      chk_state("raising_1", 3, 1, 1);
      chk("raising_count0", int'(car_count), 0);
      chk("raising_has_car", int'(has_car), 0);
      for (int k = 2; k <= RAISE_CYC; k++) begin
         step(2'b00, 2'b00, 1, 0);
         chk_state("raising_k", 3, 1, 1);
      end
      step(2'b00, 2'b00, 1, 0);
      chk_state("up_1", 4, 1, 0);
      step(2'b00, 2'b00, 1, 0);
      step(2'b00, 2'b00, 1, 0);
      chk_state("up_3", 4, 1, 0);
      for (int k = 4; k <= OPEN_MIN; k++) begin
         step(2'b00, 2'b00, 0, 0);
         chk_state("up_k", 4, 1, 0);
      end
      for (int k = 1; k <= LOWER_CYC; k++) begin
         step(2'b00, 2'b00, 0, 0);
         chk_state("lowering_k", 5, 1, 1);
      end
      step(2'b00, 2'b00, 0, 0);
      chk_state("down_again", 0, 0, 0);
      chk("seq_error", int'(error), 0);

      // Abort during lowering, then reset mid-raise.
      for (int k = 1; k <= ALERT_CYC; k++) step(2'b00, 2'b00, 1, 0);
      chk_state("b_alert_end", 1, 0, 1);
      step(2'b00, 2'b00, 1, 0);
      chk_state("b_clearing", 2, 1, 1);
      for (int k = 1; k <= RAISE_CYC; k++) step(2'b00, 2'b00, 1, 0);
      chk_state("b_raising_end", 3, 1, 1);
      for (int k = 1; k <= OPEN_MIN; k++) step(2'b00, 2'b00, 0, 0);
      chk_state("b_up_end", 4, 1, 0);
      for (int k = 1; k <= 3; k++) step(2'b00, 2'b00, 0, 0);
      chk_state("b_lowering_3", 5, 1, 1);
      step(2'b00, 2'b00, 0, 1);
      chk_state("abort_raising", 3, 1, 1);
      step(2'b01, 2'b00, 0, 0);
      chk("entry_under_barrier_cnt", int'(car_count), 1);
      chk("entry_under_barrier_err", int'(error), 1);
      rst = 1'b1;
      step(2'b00, 2'b00, 1, 1);
      chk_state("mid_reset", 0, 0, 0);
      chk("mid_reset_count", int'(car_count), 0);
      chk("mid_reset_has_car", int'(has_car), 0);
      chk("mid_reset_error", int'(error), 0);
      rst = 1'b0;

      // Underflow is clamped and the error is sticky.
      step(2'b00, 2'b01, 0, 0);
      chk("underflow_count", int'(car_count), 0);
      chk("underflow_error", int'(error), 1);
      for (int k = 0; k < 3; k++) step(2'b00, 2'b00, 0, 0);
      chk("sticky_error", int'(error), 1);
      rst = 1'b1;
      step(2'b00, 2'b00, 0, 0);
      chk("error_cleared", int'(error), 0);
      rst = 1'b0;

      // Saturation at the top of the count range.
      for (int k = 0; k < 7; k++) step(2'b11, 2'b00, 0, 0);
      chk("count_14", int'(car_count), 14);
      chk("no_sat_error", int'(error), 0);
      step(2'b11, 2'b00, 0, 0);
      chk("count_sat", int'(car_count), CMAX);
      chk("sat_error", int'(error), 1);
      step(2'b00, 2'b11, 0, 0);
      chk("count_13", int'(car_count), 13);
      step(2'b01, 2'b01, 0, 0);
      chk("same_lane_net0", int'(car_count), 13);
      step(2'b00, 2'b00, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
